// File: rtl/dense_reuse_layer.sv
// Fully-connected layer act(W*x + b) time-multiplexed over REUSE cycles:
// PAR = INPUT_SIZE/REUSE rows are multiplied per cycle for every output column.
module dense_reuse_layer #(
  parameter int WIDTH       = 5,
  parameter int NFRAC       = 3,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 4,
  parameter int REUSE       = 4,
  parameter int RELU        = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]             input_data,
  input  logic [INPUT_SIZE*OUTPUT_SIZE-1:0][WIDTH-1:0] weights,
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]            biases,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]            output_data
);
  // state    | meaning
  // IDLE     | waiting for a vector, in_ready high
  // COMPUTE  | accumulate rows k*PAR .. k*PAR+PAR-1 into every column
  // FINAL    | add bias, rescale, saturate, activate, register result
  // HOLD     | result presented until out_ready

  localparam int PAR = INPUT_SIZE / REUSE;
  localparam int PW  = 2 * WIDTH;
  localparam int AW  = 2 * WIDTH + $clog2(INPUT_SIZE) + 1;
  localparam int KW  = (REUSE > 1) ? $clog2(REUSE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(REUSE - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINAL, S_HOLD} state_t;

  state_t                           state;
  logic [KW-1:0]                    k;
  logic [INPUT_SIZE-1:0][WIDTH-1:0] x_reg;
  logic signed [AW-1:0]             acc [OUTPUT_SIZE];

  logic signed [WIDTH-1:0]          x_sel  [PAR];
  logic signed [WIDTH-1:0]          w_sel  [PAR][OUTPUT_SIZE];
  logic signed [PW-1:0]             prod   [PAR][OUTPUT_SIZE];
  logic signed [AW-1:0]             psum   [OUTPUT_SIZE];
  logic signed [AW-1:0]             biased [OUTPUT_SIZE];
  logic signed [AW-1:0]             scaled [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0] res;

  assign in_ready = (state == S_IDLE);

  // Row-slice mux: k picks which PAR rows feed the shared multipliers.
  always_comb begin
    for (int p = 0; p < PAR; p++) begin
      x_sel[p] = '0;
      for (int c = 0; c < OUTPUT_SIZE; c++) w_sel[p][c] = '0;
    end
    for (int j = 0; j < REUSE; j++) begin
      if (k == KW'(j)) begin
        for (int p = 0; p < PAR; p++) begin
          x_sel[p] = x_reg[j*PAR+p];
          for (int c = 0; c < OUTPUT_SIZE; c++)
            w_sel[p][c] = weights[(j*PAR+p)*OUTPUT_SIZE+c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < OUTPUT_SIZE; c++) begin
      psum[c] = '0;
      for (int p = 0; p < PAR; p++) begin
        prod[p][c] = $signed({{WIDTH{x_sel[p][WIDTH-1]}}, x_sel[p]}) *
                     $signed({{WIDTH{w_sel[p][c][WIDTH-1]}}, w_sel[p][c]});
        psum[c] = psum[c] + $signed({{(AW-PW){prod[p][c][PW-1]}}, prod[p][c]});
      end
    end
  end

  // Bias is aligned to the 2*NFRAC product scale before the floor shift.
  always_comb begin
    res = '0;
    for (int c = 0; c < OUTPUT_SIZE; c++) begin
      biased[c] = acc[c] + $signed({{(AW-WIDTH-NFRAC){biases[c][WIDTH-1]}},
                                    biases[c], {NFRAC{1'b0}}});
      scaled[c] = biased[c] >>> NFRAC;
      if ((RELU != 0) && (scaled[c] < 0))
        res[c] = '0;
      else if (scaled[c] > SAT_MAX)
        res[c] = SAT_MAX[WIDTH-1:0];
      else if (scaled[c] < SAT_MIN)
        res[c] = SAT_MIN[WIDTH-1:0];
      else
        res[c] = scaled[c][WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      k           <= '0;
      x_reg       <= '0;
      out_valid   <= 1'b0;
      output_data <= '0;
      for (int c = 0; c < OUTPUT_SIZE; c++) acc[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= input_data;
            k     <= '0;
            for (int c = 0; c < OUTPUT_SIZE; c++) acc[c] <= '0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          for (int c = 0; c < OUTPUT_SIZE; c++) acc[c] <= acc[c] + psum[c];
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_FINAL;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_FINAL: begin
          output_data <= res;
          out_valid   <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_reuse_layer.sv
// Scoreboard bench: six layer instances (REUSE 1/2/4 x linear/ReLU) share stimulus;
// expectations are queued at acceptance and checked at each output handshake.
module tb_dense_reuse_layer;
  localparam int W = 4, NF = 2, IN = 4, OUT = 3, NCFG = 6;

  typedef logic [IN-1:0][W-1:0]     xv_t;
  typedef logic [IN*OUT-1:0][W-1:0] wv_t;
  typedef logic [OUT-1:0][W-1:0]    vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, out_ready;
  xv_t  input_data;
  wv_t  weights;
  vec_t biases;

  logic in_ready_a  [NCFG];
  logic out_valid_a [NCFG];
  vec_t out_a       [NCFG];

  vec_t exp_lin, exp_relu;
  vec_t exp_q [NCFG][$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   ii_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d: got 0x%0h expected 0x%0h", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int RU = (g < 2) ? 1 : ((g < 4) ? 2 : 4);
    localparam bit RL = (g % 2) == 1;
    int   acc_edge = 0, prev_acc = 0;
    bit   prev_v = 1'b0, have_prev = 1'b0;
    vec_t e;

    dense_reuse_layer #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT),
                        .REUSE(RU), .RELU(RL ? 1 : 0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a[g]),
      .input_data(input_data), .weights(weights), .biases(biases),
      .out_valid(out_valid_a[g]), .out_ready(out_ready), .output_data(out_a[g]));

    always @(negedge clk) begin
      if (!reset) begin
        exp_q[g].delete();
        prev_v    = 1'b0;
        have_prev = 1'b0;
      end else begin
        if (!ii_on) have_prev = 1'b0;
        if (in_valid && in_ready_a[g]) begin
          exp_q[g].push_back(RL ? exp_relu : exp_lin);
          acc_edge = cyc + 1;
          if (ii_on && have_prev) check("interval", g, 32'(acc_edge - prev_acc), 32'(RU + 3));
          have_prev = ii_on;
          prev_acc  = acc_edge;
        end
        if (out_valid_a[g] && !prev_v) check("latency", g, 32'(cyc - acc_edge), 32'(RU + 1));
        prev_v = out_valid_a[g];
        if (out_valid_a[g]) begin
          if (exp_q[g].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output cfg%0d: got 0x%0h expected none", g, out_a[g]);
          end else if (out_ready) begin
            e = exp_q[g].pop_front();
            check("output", g, 32'(out_a[g]), 32'(e));
          end else begin
            check("hold_in_ready", g, 32'(in_ready_a[g]), 32'd0);
            check("hold_stable", g, 32'(out_a[g]), 32'(exp_q[g][0]));
          end
        end
      end
    end
  end

  function automatic vec_t model(input xv_t x, input wv_t w, input vec_t b, input bit relu);
    vec_t r;
    for (int c = 0; c < OUT; c++) begin
      int acc = 0;
      int t;
      for (int i = 0; i < IN; i++) acc += $signed(x[i]) * $signed(w[i*OUT+c]);
      t = (acc + $signed(b[c]) * (1 << NF)) >>> NF;
      if (t > 7) t = 7;
      if (t < -8) t = -8;
      if (relu && t < 0) t = 0;
      r[c] = W'(t);
    end
    return r;
  endfunction

  function automatic vec_t v3(input int a, input int b, input int c);
    vec_t r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c);
    return r;
  endfunction

  function automatic xv_t fill_x(input int v);
    xv_t r;
    for (int i = 0; i < IN; i++) r[i] = W'(v);
    return r;
  endfunction

  function automatic wv_t fill_w(input int v);
    wv_t r;
    for (int i = 0; i < IN*OUT; i++) r[i] = W'(v);
    return r;
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = 1'b1;
      for (int g = 0; g < NCFG; g++) if (!in_ready_a[g]) ok = 1'b0;
      if (!ok) begin @(posedge clk); #1; end
    end
    check("idle_timeout", -1, 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk); #1;
      ok = 1'b1;
      for (int g = 0; g < NCFG; g++)
        if (exp_q[g].size() != 0 || out_valid_a[g] || !in_ready_a[g]) ok = 1'b0;
    end
    check("drain_timeout", -1, 32'(ok), 32'd1);
  endtask

  task automatic issue(input xv_t x, input wv_t w, input vec_t b, input vec_t el, input vec_t er);
    wait_idle();
    input_data = x; weights = w; biases = b;
    exp_lin = el; exp_relu = er;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input xv_t x, input wv_t w, input vec_t b, input vec_t el, input vec_t er);
    issue(x, w, b, el, er);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    xv_t  tx;
    wv_t  tw;
    vec_t tb_b;
    bit   ok;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    input_data = '0; weights = '0; biases = '0; exp_lin = '0; exp_relu = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      check("rst_out_valid", g, 32'(out_valid_a[g]), 32'd0);
      check("rst_in_ready", g, 32'(in_ready_a[g]), 32'd1);
      check("rst_output", g, 32'(out_a[g]), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed: basic, bias, saturation, activation, truncation
    send(fill_x(4), fill_w(1), v3(0, 0, 0), v3(4, 4, 4), v3(4, 4, 4));
    send(fill_x(4), fill_w(1), v3(1, 0, 0), v3(5, 4, 4), v3(5, 4, 4));
    send(fill_x(4), fill_w(2), v3(0, 0, 0), v3(7, 7, 7), v3(7, 7, 7));
    send(fill_x(4), fill_w(-8), v3(0, 0, 0), v3(-8, -8, -8), v3(0, 0, 0));
    send(fill_x(4), fill_w(-1), v3(0, 0, 0), v3(-4, -4, -4), v3(0, 0, 0));
    tx = fill_x(0); tx[0] = 4'd1;
    tw = fill_w(0);
    for (int c = 0; c < OUT; c++) tw[c] = 4'hF;
    send(tx, tw, v3(0, 0, 0), v3(-1, -1, -1), v3(0, 0, 0));

    // Backpressure: hold out_ready low while a second vector waits
    out_ready = 1'b0;
    issue(fill_x(4), fill_w(1), v3(0, 0, 0), v3(4, 4, 4), v3(4, 4, 4));
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk); #1;
      ok = 1'b1;
      for (int g = 0; g < NCFG; g++) if (!out_valid_a[g]) ok = 1'b0;
    end
    check("valid_timeout", -1, 32'(ok), 32'd1);
    input_data = fill_x(4); weights = fill_w(2); biases = '0;
    exp_lin = v3(7, 7, 7); exp_relu = v3(7, 7, 7);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();

    // Streaming with in_valid held: initiation interval REUSE+3
    wait_idle();
    input_data = fill_x(3); weights = fill_w(1); biases = v3(-1, 2, 0);
    exp_lin = v3(2, 5, 3); exp_relu = v3(2, 5, 3);
    ii_on = 1'b1;
    in_valid = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    in_valid = 1'b0;
    ii_on = 1'b0;
    wait_done();

    // Reset during COMPUTE: aborted vector leaves no residue
    issue(fill_x(4), fill_w(2), v3(7, 7, 7), v3(7, 7, 7), v3(7, 7, 7));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      check("midrst_out_valid", g, 32'(out_valid_a[g]), 32'd0);
      check("midrst_in_ready", g, 32'(in_ready_a[g]), 32'd1);
      check("midrst_output", g, 32'(out_a[g]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    send(fill_x(4), fill_w(1), v3(0, 0, 0), v3(4, 4, 4), v3(4, 4, 4));

    // Random regression against the golden model
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < IN; i++) tx[i] = W'($urandom_range(0, 15));
      for (int i = 0; i < IN*OUT; i++) tw[i] = W'($urandom_range(0, 15));
      for (int c = 0; c < OUT; c++) tb_b[c] = W'($urandom_range(0, 15));
      send(tx, tw, tb_b, model(tx, tw, tb_b, 1'b0), model(tx, tw, tb_b, 1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
